// File: rtl/uart_rx_word.sv
// 8N1 UART receiver that frames bytes from the serial pin and packs BYTES of them
// into a 64-bit word, with framing check and inter-byte timeout.
module uart_rx_word #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned BYTES        = 8,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_pin_in,
  output logic [7:0]  byte_data,
  output logic        byte_valid,
  output logic [63:0] word_data,
  output logic        word_valid,
  output logic        frame_err,
  output logic        timeout,
  output logic        busy
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned GAP_W = 32;
  localparam int unsigned IDX_W = 4;

  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
  localparam logic [63:0]      WORD_MASK = (BYTES >= 8) ? {64{1'b1}}
                                           : ((64'd1 << (8 * BYTES)) - 64'd1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic             rx_meta, rxs;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shreg, shreg_nxt;
  logic             store_pend, store_pend_nxt;
  logic             break_hold, break_hold_nxt;
  logic [IDX_W-1:0] byte_idx, byte_idx_nxt;
  logic [GAP_W-1:0] gap, gap_nxt;
  logic [63:0]      acc, acc_nxt;
  logic [7:0]       byte_data_nxt;
  logic [63:0]      word_data_nxt;
  logic             byte_valid_nxt, word_valid_nxt, frame_err_nxt, timeout_nxt;

  // Two-flop synchroniser; resets to idle-high so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_pin_in;
      rxs     <= rx_meta;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      store_pend <= 1'b0;
      break_hold <= 1'b0;
      byte_idx   <= '0;
      gap        <= '0;
      acc        <= '0;
      byte_data  <= '0;
      word_data  <= '0;
      byte_valid <= 1'b0;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      timeout    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      store_pend <= store_pend_nxt;
      break_hold <= break_hold_nxt;
      byte_idx   <= byte_idx_nxt;
      gap        <= gap_nxt;
      acc        <= acc_nxt;
      byte_data  <= byte_data_nxt;
      word_data  <= word_data_nxt;
      byte_valid <= byte_valid_nxt;
      word_valid <= word_valid_nxt;
      frame_err  <= frame_err_nxt;
      timeout    <= timeout_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

  // Next-state, sampling, word assembly and pulse generation
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    bit_idx_nxt    = bit_idx;
    shreg_nxt      = shreg;
    store_pend_nxt = 1'b0;
    break_hold_nxt = break_hold;
    byte_idx_nxt   = byte_idx;
    gap_nxt        = gap;
    acc_nxt        = acc;
    byte_data_nxt  = byte_data;
    word_data_nxt  = word_data;
    byte_valid_nxt = 1'b0;
    word_valid_nxt = 1'b0;
    frame_err_nxt  = 1'b0;
    timeout_nxt    = 1'b0;

    // Idle gap inside a partial word; on expiry the partial word is dropped
    if (state == IDLE && byte_idx != '0) begin
      if (gap == GAP_LAST) begin
        timeout_nxt  = 1'b1;
        byte_idx_nxt = '0;
        gap_nxt      = '0;
      end else begin
        gap_nxt = gap + GAP_W'(1);
      end
    end

    // Commit a well-framed byte the cycle after its stop bit was sampled
    if (store_pend) begin
      byte_data_nxt  = shreg;
      byte_valid_nxt = 1'b1;
      acc_nxt        = (acc << 8) | 64'(shreg);
      if (byte_idx_nxt == LAST_IDX) begin
        word_data_nxt  = ((acc << 8) | 64'(shreg)) & WORD_MASK;
        word_valid_nxt = 1'b1;
        byte_idx_nxt   = '0;
      end else begin
        byte_idx_nxt = byte_idx_nxt + IDX_W'(1);
      end
    end

    case (state)
      IDLE: begin
        if (break_hold) begin
          if (rxs) break_hold_nxt = 1'b0;
        end else if (!rxs) begin
          state_nxt = START;
          cnt_nxt   = HALF_LOAD;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (!rxs) begin
            state_nxt   = DATA;
            bit_idx_nxt = '0;
            cnt_nxt     = BIT_LOAD;
            gap_nxt     = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_nxt[bit_idx] = rxs;
          cnt_nxt            = BIT_LOAD;
          if (bit_idx == 3'd7) state_nxt = STOP;
          else                 bit_idx_nxt = bit_idx + 3'd1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          if (rxs) begin
            store_pend_nxt = 1'b1;
          end else begin
            // Bad stop: drop byte and partial word, wait for line high before re-arming
            frame_err_nxt  = 1'b1;
            byte_idx_nxt   = '0;
            break_hold_nxt = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: directed scenarios plus random frames against a byte/word queue model.
module tb_uart_rx_word;

  localparam int unsigned CPB    = 16;
  localparam int unsigned NB     = 8;
  localparam int unsigned TOB    = 20;
  localparam int          BIT_NS = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_pin_in;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [63:0] word_data;
  logic        word_valid;
  logic        frame_err;
  logic        timeout;
  logic        busy;

  always #5 clk = ~clk;

  uart_rx_word #(.CLKS_PER_BIT(CPB), .BYTES(NB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .rx_pin_in(rx_pin_in),
    .byte_data(byte_data), .byte_valid(byte_valid),
    .word_data(word_data), .word_valid(word_valid),
    .frame_err(frame_err), .timeout(timeout), .busy(busy)
  );

  int errors = 0;
  int checks = 0;

  // Observed events
  logic [7:0]  byte_log[$];
  time         bv_time[$];
  logic [63:0] word_log[$];
  int ferr_cnt = 0, to_cnt = 0, bad_coinc = 0, overlap = 0;

  // Reference model state
  logic [7:0]  exp_bytes[$];
  logic [7:0]  part[$];
  logic [63:0] exp_words[$];
  int          exp_ferr = 0, exp_to = 0;
  logic [7:0]  last_byte = 8'h00;

  logic [7:0]  t1_bytes [8] = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
  logic [7:0]  b;
  time         t_fall, lat;
  int          r;

  always @(negedge clk) begin
    if (byte_valid) begin
      byte_log.push_back(byte_data);
      bv_time.push_back($time - 5);
    end
    if (word_valid) word_log.push_back(word_data);
    if (word_valid && !byte_valid) bad_coinc++;
    if (byte_valid && frame_err) overlap++;
    if (frame_err) ferr_cnt++;
    if (timeout) to_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] d);
    logic [63:0] w;
    exp_bytes.push_back(d);
    last_byte = d;
    part.push_back(d);
    if (part.size() == int'(NB)) begin
      w = '0;
      foreach (part[i]) w = (w << 8) | 64'(part[i]);
      exp_words.push_back(w);
      part.delete();
    end
  endtask

  task automatic model_idle(input int bits);
    if (part.size() != 0 && bits > int'(TOB)) begin
      exp_to++;
      part.delete();
    end
  endtask

  task automatic send(input logic [7:0] d, input logic good);
    rx_pin_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      rx_pin_in = d[i];
      #(BIT_NS);
    end
    rx_pin_in = good;
    #(BIT_NS);
    rx_pin_in = 1'b1;
    if (good) begin
      model_byte(d);
    end else begin
      exp_ferr++;
      part.delete();
      #(BIT_NS);
    end
  endtask

  task automatic idle(input int bits);
    rx_pin_in = 1'b1;
    #(BIT_NS * bits);
    model_idle(bits);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_byte_data"}, 64'(byte_data), 64'd0);
    check({tag, "_byte_valid"}, 64'(byte_valid), 64'd0);
    check({tag, "_word_data"}, word_data, 64'd0);
    check({tag, "_word_valid"}, 64'(word_valid), 64'd0);
    check({tag, "_frame_err"}, 64'(frame_err), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic compare_phase(input string tag);
    check({tag, "_byte_count"}, 64'(byte_log.size()), 64'(exp_bytes.size()));
    for (int i = 0; i < byte_log.size() && i < exp_bytes.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), 64'(byte_log[i]), 64'(exp_bytes[i]));
    check({tag, "_word_count"}, 64'(word_log.size()), 64'(exp_words.size()));
    for (int i = 0; i < word_log.size() && i < exp_words.size(); i++)
      check($sformatf("%s_word%0d", tag, i), word_log[i], exp_words[i]);
    check({tag, "_frame_err_count"}, 64'(ferr_cnt), 64'(exp_ferr));
    check({tag, "_timeout_count"}, 64'(to_cnt), 64'(exp_to));
    check({tag, "_word_without_byte"}, 64'(bad_coinc), 64'd0);
    check({tag, "_byte_and_ferr"}, 64'(overlap), 64'd0);
    check({tag, "_byte_data_hold"}, 64'(byte_data), 64'(last_byte));
    byte_log.delete();
    bv_time.delete();
    word_log.delete();
    exp_bytes.delete();
    exp_words.delete();
    ferr_cnt = 0; to_cnt = 0; bad_coinc = 0; overlap = 0;
    exp_ferr = 0; exp_to = 0;
  endtask

  initial begin
    rst_n     = 1'b0;
    rx_pin_in = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("por");
    rst_n = 1'b1;
    #(BIT_NS * 2);

    // Eight back-to-back bytes forming one word; first frame also times the latency
    t_fall = $time;
    for (int i = 0; i < 8; i++) send(t1_bytes[i], 1'b1);
    idle(2);
    lat = (bv_time.size() > 0) ? bv_time[0] - t_fall : 0;
    check("t1_latency_in_window", 64'((lat >= 1540 && lat <= 1561) ? 1 : 0), 64'd1);
    check("t1_word_literal", (word_log.size() > 0) ? word_log[0] : 64'hDEAD, 64'h0123456789ABCDEF);
    compare_phase("t1");

    // Bad stop bit, then a clean word
    send(8'h55, 1'b0);
    idle(1);
    compare_phase("t2_ferr");
    for (int i = 0; i < 8; i++) send(8'(i), 1'b1);
    idle(2);
    check("t2_word_literal", (word_log.size() > 0) ? word_log[0] : 64'hDEAD, 64'h0001020304050607);
    compare_phase("t2");

    // Partial word abandoned by the gap timer
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b1);
    idle(21);
    compare_phase("t3_timeout");
    for (int i = 0; i < 8; i++) send(8'(8'hF0 + i), 1'b1);
    idle(2);
    check("t3_word_literal", (word_log.size() > 0) ? word_log[0] : 64'hDEAD, 64'hF0F1F2F3F4F5F6F7);
    compare_phase("t3");

    // Short low glitch on an idle line
    rx_pin_in = 1'b0;
    #50;
    rx_pin_in = 1'b1;
    #90;
    check("t4_busy_after_glitch", 64'(busy), 64'd0);
    compare_phase("t4_glitch");
    send(8'hA5, 1'b1);
    idle(25);
    compare_phase("t4");

    // Reset during data bit 4 of byte 6
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b1);
    b = 8'($urandom);
    rx_pin_in = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx_pin_in = b[i];
      #(BIT_NS);
    end
    rx_pin_in = b[4];
    #(BIT_NS / 2);
    rst_n = 1'b0;
    #30;
    check_reset_outputs("t5_in_reset");
    rx_pin_in = 1'b1;
    #20;
    rst_n = 1'b1;
    part.delete();
    last_byte = 8'h00;
    #(BIT_NS * 2);
    for (int i = 1; i <= 8; i++) send(8'(8'h11 * i), 1'b1);
    idle(2);
    check("t5_word_literal", (word_log.size() > 0) ? word_log[0] : 64'hDEAD, 64'h1122334455667788);
    compare_phase("t5");

    // Line held low for 40 bit-times
    rx_pin_in = 1'b0;
    #(BIT_NS * 40);
    rx_pin_in = 1'b1;
    exp_ferr++;
    part.delete();
    #(BIT_NS * 2);
    compare_phase("t6_break");
    send(8'($urandom), 1'b1);
    idle(25);
    compare_phase("t6");

    // Random frames, occasional bad stops and long gaps
    for (int n = 0; n < 40; n++) begin
      b = 8'($urandom);
      send(b, ($urandom_range(7) != 0) ? 1'b1 : 1'b0);
      r = int'($urandom_range(9));
      if (r == 0)      idle(25);
      else if (r < 4)  idle(int'($urandom_range(3)));
    end
    idle(25);
    compare_phase("rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_word.md
Name: uart_rx_word

Overview:
- Receive-side counterpart of the board UART link's 64-bit word transmitter.
- Deserialises 8N1 UART frames from rx_pin_in into bytes, then packs BYTES consecutive bytes into one 64-bit word for the MIPS side.
- Runs on the divided UART clock clk_trx (50 MHz on board).
- Includes a mid-bit sampler, framing check, inter-byte timeout and word assembly.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (50 MHz / 115200); legal range 8..65535.
- BYTES, 8, bytes per assembled word; legal range 1..8.
- TIMEOUT_BITS, 20, idle bit-times allowed between bytes before a partial word is discarded.

Ports:
- clk  in  1  UART clock (clk_trx).
- rst_n  in  1  asynchronous active-low reset.
- rx_pin_in  in  1  serial input; idle high; asynchronous to clk.
- byte_data  out  8  last correctly framed byte.
- byte_valid  out  1  one-cycle pulse when byte_data updates.
- word_data  out  64  assembled word; first received byte in [8*BYTES-1 -: 8], last byte in [7:0]; unused upper bits are 0.
- word_valid  out  1  one-cycle pulse when word_data updates.
- frame_err  out  1  one-cycle pulse on bad stop bit.
- timeout  out  1  one-cycle pulse when a partial word is discarded.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset: the design has one clock; reset is asynchronous and active-low. All outputs, counters and shift registers clear to 0. Both synchroniser flops reset to 1, so reset does not create a false start edge. FSM goes to IDLE and byte index to 0.
- Reset mid-frame or mid-word: the partial byte and partial word are lost. No pulse is emitted.
- Synchroniser: 2-flop synchroniser on rx_pin_in. All logic uses the synchronised value rxs. Pin-to-rxs latency is 2 clk.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: on rxs = 0, go to START and load bit counter with CLKS_PER_BIT/2 - 1 (integer division).
  - START: when the counter reaches 0, sample rxs.
    - rxs = 0: go to DATA, bit index = 0, counter = CLKS_PER_BIT - 1.
    - rxs = 1: glitch. Return to IDLE with no pulse.
  - DATA: each time the counter reaches 0, shift rxs into bit [bit index] (LSB first) and reload the counter. After bit 7 is sampled, go to STOP.
  - STOP: when the counter reaches 0, sample rxs.
    - rxs = 1: in the next cycle, update byte_data, pulse byte_valid, store the byte in the word, increment byte index. Go to IDLE.
    - rxs = 0: pulse frame_err, discard the byte, clear byte index to 0 (partial word dropped), go to IDLE. IDLE re-arms only after rxs has been observed high, so a line held low (break) yields exactly one frame_err.
- Back-to-back frames: returning to IDLE at mid-stop means a start edge immediately after the stop bit is caught. There are no dead cycles.
- Word completion: when the stored byte is number BYTES, in the same cycle:
  - update word_data;
  - pulse word_valid together with byte_valid;
  - reset byte index to 0.
  word_data holds its value until the next completion.
- Timeout: a gap counter runs in IDLE while byte index > 0 and clears whenever a start bit is accepted. When it reaches TIMEOUT_BITS*CLKS_PER_BIT, clear byte index and pulse timeout. If timeout and a start edge occur in the same cycle, timeout wins and the new frame is still received as byte 0.
- Latency: byte_valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clk after the pin's falling start edge, with ±1 clk tolerance for synchroniser phase.
- busy = (state != IDLE).
- Pulse exclusivity: byte_valid and frame_err are never high together.

Test Plan:
- CLKS_PER_BIT=16, BYTES=8. Send 0x01,0x23,0x45,0x67,0x89,0xAB,0xCD,0xEF back-to-back → expect:
  - 8 byte_valid pulses;
  - one word_valid with word_data=0x0123456789ABCDEF, coincident with the 8th byte_valid;
  - no frame_err or timeout.
- Send byte 0x55 with stop bit = 0 → frame_err for exactly 1 cycle, no byte_valid, byte_data unchanged. Then send 8 bytes 0x00..0x07 → word_data=0x0001020304050607.
- Send 3 bytes, then idle for 21 bit-times → timeout pulse once. Then send 8 bytes 0xF0..0xF7 → word_data=0xF0F1F2F3F4F5F6F7 (earlier partial bytes absent).
- Drive a 5-cycle low glitch on the idle line → no pulses, busy returns low within 9 cycles, next valid frame 0xA5 received correctly.
- Assert rst_n low at data bit 4 of byte 6 of a word, release, then send 8 fresh bytes 0x11..0x88 (step 0x11) → exactly one word_valid with word_data=0x1122334455667788; all outputs read 0 during reset.
- Hold rx_pin_in low for 40 bit-times → exactly one frame_err. After release high, the next frame is received normally.
